// File: rtl/bin_from_bcd_seq_if.sv
// Handshake bundle for the BCD-to-binary converter: BCD word in, binary result out.
interface bin_from_bcd_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] bcd_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] bin_out;
  logic       ovf;
  logic       err;

  modport master (
    output in_valid, bcd_in, out_ready,
    input  in_ready, out_valid, bin_out, ovf, err
  );

  modport slave (
    input  in_valid, bcd_in, out_ready,
    output in_ready, out_valid, bin_out, ovf, err
  );
endinterface

// File: rtl/bin_from_bcd_seq.sv
// Iterative reverse double-dabble decoder: 3-digit packed BCD (h:2,t:4,o:4) to 8-bit binary.
// Optional macro BIN_FROM_BCD_SAT_EN saturates overflowing results to 8'hFF.
module bin_from_bcd_seq #(
  parameter int ITER = 9
) (
  input  logic           clk,
  input  logic           rst,
  bin_from_bcd_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(ITER - 1);

  state_t      state_q, state_d;
  logic [11:0] bcd_p0;
  logic [8:0]  acc_p0;
  logic [3:0]  cnt_p0;
  logic        err_p0;
  logic [7:0]  bin_p1;
  logic        ovf_p1;
  logic        err_p1;
  logic [20:0] step_v;

  // One iteration: shift right, then correct every nibble that landed at 8 or above.
  function automatic logic [20:0] dabble_step(input logic [20:0] v);
    logic [20:0] s;
    s = v >> 1;
    if (s[20:17] >= 4'd8) s[20:17] = s[20:17] - 4'd3;
    if (s[16:13] >= 4'd8) s[16:13] = s[16:13] - 4'd3;
    if (s[12:9]  >= 4'd8) s[12:9]  = s[12:9]  - 4'd3;
    return s;
  endfunction

  // Result formatting: {err, ovf, bin}; an invalid digit forces a zero result.
  function automatic logic [9:0] finalize(input logic [8:0] acc, input logic e);
    logic [9:0] r;
    if (e) begin
      r = {1'b1, 1'b0, 8'h00};
    end else if (acc[8]) begin
`ifdef BIN_FROM_BCD_SAT_EN
      r = {1'b0, 1'b1, 8'hFF};
`else
      r = {1'b0, 1'b1, acc[7:0]};
`endif
    end else begin
      r = {1'b0, 1'b0, acc[7:0]};
    end
    return r;
  endfunction

  assign step_v = dabble_step({bcd_p0, acc_p0});

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = SHIFT;
      end
      SHIFT: begin
        if (cnt_p0 == LAST_CNT) state_d = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: iterative shift datapath; stage p1: held result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_p0 <= '0;
      acc_p0 <= '0;
      cnt_p0 <= '0;
      err_p0 <= 1'b0;
      bin_p1 <= '0;
      ovf_p1 <= 1'b0;
      err_p1 <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            bcd_p0 <= {2'b00, bus.bcd_in};
            acc_p0 <= '0;
            cnt_p0 <= '0;
            err_p0 <= (bus.bcd_in[7:4] > 4'd9) | (bus.bcd_in[3:0] > 4'd9);
          end
        end
        SHIFT: begin
          {bcd_p0, acc_p0} <= step_v;
          cnt_p0           <= cnt_p0 + 4'd1;
          if (cnt_p0 == LAST_CNT)
            {err_p1, ovf_p1, bin_p1} <= finalize(step_v[8:0], err_p0);
        end
        default: ;
      endcase
    end
  end

  assign bus.bin_out = bin_p1;
  assign bus.ovf     = ovf_p1;
  assign bus.err     = err_p1;

endmodule

// File: tb/tb_bin_from_bcd_seq.sv
// Directed bench for bin_from_bcd_seq: known vectors, full 0..255 round trip, hold and abort cases.
module tb_bin_from_bcd_seq;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   lat;

  bin_from_bcd_seq_if bus();

  bin_from_bcd_seq #(.ITER(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Independent binary-to-BCD encoder model.
  function automatic logic [9:0] enc(input int v);
    logic [1:0] h;
    logic [3:0] t, o;
    h = 2'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  // Called right after the acceptance edge; counts edges until out_valid shows.
  task automatic wait_done(output int n);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic start(input logic [9:0] b);
    bus.bcd_in   = b;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.bcd_in    = '0;
    bus.out_ready = 1'b1;
    step();
    step();
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_bin", 32'(bus.bin_out), 0);
    chk("rst_ovf", 32'(bus.ovf), 0);
    chk("rst_err", 32'(bus.err), 0);
    rst = 1'b0;
    step();

    // 255 -> FF
    start(10'h255);
    chk("255_busy", 32'(bus.in_ready), 0);
    wait_done(lat);
    chk("255_lat", 32'(lat), 9);
    chk("255_bin", 32'(bus.bin_out), 32'hFF);
    chk("255_ovf", 32'(bus.ovf), 0);
    chk("255_err", 32'(bus.err), 0);
    step();
    chk("255_hs_valid", 32'(bus.out_valid), 0);
    chk("255_hs_ready", 32'(bus.in_ready), 1);
    chk("255_hs_keep", 32'(bus.bin_out), 32'hFF);

    // 299 -> overflow
    start(10'h299);
    wait_done(lat);
    chk("299_lat", 32'(lat), 9);
`ifdef BIN_FROM_BCD_SAT_EN
    chk("299_bin", 32'(bus.bin_out), 32'hFF);
`else
    chk("299_bin", 32'(bus.bin_out), 32'h2B);
`endif
    chk("299_ovf", 32'(bus.ovf), 1);
    chk("299_err", 32'(bus.err), 0);
    step();

    // Invalid tens digit
    start(10'h0A5);
    wait_done(lat);
    chk("0A5_lat", 32'(lat), 9);
    chk("0A5_err", 32'(bus.err), 1);
    chk("0A5_bin", 32'(bus.bin_out), 0);
    chk("0A5_ovf", 32'(bus.ovf), 0);
    step();

    // Invalid ones digit
    start(10'h11F);
    wait_done(lat);
    chk("11F_err", 32'(bus.err), 1);
    chk("11F_bin", 32'(bus.bin_out), 0);
    step();

    // Hundreds field 3: only overflow is defined
    start(10'h300);
    wait_done(lat);
    chk("300_ovf", 32'(bus.ovf), 1);
    chk("300_err", 32'(bus.err), 0);
    step();

    // Round trip through the encoder model
    for (int v = 0; v < 256; v++) begin
      start(enc(v));
      wait_done(lat);
      chk("sweep_lat", 32'(lat), 9);
      chk("sweep_bin", 32'(bus.bin_out), 32'(v));
      chk("sweep_ovf", 32'(bus.ovf), 0);
      chk("sweep_err", 32'(bus.err), 0);
      step();
    end

    // Back-pressure hold with a stray in_valid
    bus.out_ready = 1'b0;
    start(10'h128);
    wait_done(lat);
    chk("128_lat", 32'(lat), 9);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus.bcd_in   = 10'h011;
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      chk("hold_valid", 32'(bus.out_valid), 1);
      chk("hold_bin", 32'(bus.bin_out), 32'h80);
      chk("hold_ready", 32'(bus.in_ready), 0);
      step();
    end
    bus.in_valid = 1'b0;
    chk("hold_end_bin", 32'(bus.bin_out), 32'h80);
    bus.out_ready = 1'b1;
    step();
    chk("128_hs_valid", 32'(bus.out_valid), 0);
    chk("128_hs_ready", 32'(bus.in_ready), 1);
    for (int i = 0; i < 12; i++) step();
    chk("stray_ignored_valid", 32'(bus.out_valid), 0);
    chk("stray_ignored_ready", 32'(bus.in_ready), 1);
    chk("stray_ignored_bin", 32'(bus.bin_out), 32'h80);

    // Abort with reset at E4
    start(10'h199);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_valid", 32'(bus.out_valid), 0);
    chk("abort_ready", 32'(bus.in_ready), 1);
    chk("abort_bin", 32'(bus.bin_out), 0);
    chk("abort_ovf", 32'(bus.ovf), 0);
    chk("abort_err", 32'(bus.err), 0);
    begin
      int seen = 0;
      for (int i = 0; i < 14; i++) begin
        if (bus.out_valid) seen++;
        step();
      end
      chk("abort_no_valid", 32'(seen), 0);
    end

    // Converter still works after the abort
    start(10'h042);
    wait_done(lat);
    chk("042_lat", 32'(lat), 9);
    chk("042_bin", 32'(bus.bin_out), 32'h2A);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
